// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver for 1-start / DATA_BITS-data / 1-stop
// frames, no parity, data LSB-first. It samples each bit at its centre and
// delivers each byte with a one-cycle strobe. A low stop bit is reported as a
// framing error. The receiver then waits for the line to return high before
// it looks for another start bit.
//
// Ports:
//   clk_in            oversampled clock (baud x OVERSAMPLING)
//   nrst_in           asynchronous active-low reset
//   rx_serial_in      asynchronous serial line, idle high
//   rx_data_out       last correctly framed word (held until the next one)
//   rx_valid_out      one-cycle pulse: new word on rx_data_out
//   rx_frame_err_out  one-cycle pulse: stop bit sampled low
//   rx_busy_out       high whenever the receiver is not idle
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on the synchronised line
// S_START | counting to mid start bit to confirm it (rejects glitches)
// S_DATA  | sampling DATA_BITS data bits, one every OVERSAMPLING cycles
// S_STOP  | sampling the stop bit at its centre
// S_BREAK | stop bit was low; hold off until the line returns high
module uart_rx #(
    parameter int OVERSAMPLING = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 rx_serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    output logic                 rx_frame_err_out,
    output logic                 rx_busy_out
);

    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   rx_sync;

    assign rx_sync = sync2_q;

    always_comb begin
        sync1_d   = rx_serial_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_sync) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    // Shifting in from the top puts the first-received bit
                    // at bit 0 once all DATA_BITS samples are in.
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    // Going idle at mid stop bit lets a start edge that
                    // arrives right at the stop-bit end be caught.
                    if (rx_sync) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_sync) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_data_out      = data_q;
    assign rx_valid_out     = valid_q;
    assign rx_frame_err_out = err_q;
    assign rx_busy_out      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. Instance A uses the default parameters. Instance B
// uses OVERSAMPLING=16 and DATA_BITS=7. Expected strobe cycles come from the
// sample-timing rule: the stop bit is sampled at edge
// e0 + 2 + OS/2 + (DB+1)*OS, where e0 is the first edge that sees the start
// bit. The strobe is visible in the cycle that follows that edge.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx_a, rx_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, err_a, busy_a;
    logic       valid_b, err_b, busy_b;

    always #5 clk = ~clk;

    uart_rx #(.OVERSAMPLING(8), .DATA_BITS(8)) dut_a (
        .clk_in(clk), .nrst_in(nrst), .rx_serial_in(rx_a),
        .rx_data_out(data_a), .rx_valid_out(valid_a),
        .rx_frame_err_out(err_a), .rx_busy_out(busy_a));

    uart_rx #(.OVERSAMPLING(16), .DATA_BITS(7)) dut_b (
        .clk_in(clk), .nrst_in(nrst), .rx_serial_in(rx_b),
        .rx_data_out(data_b), .rx_valid_out(valid_b),
        .rx_frame_err_out(err_b), .rx_busy_out(busy_b));

    typedef struct {
        int         cyc;
        bit         v;
        bit         e;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_v;
        logic       exp_e;
        logic [7:0] exp_d;
    } vec_t;

    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;
    int  busy_cnt_a = 0;
    int  both_cnt = 0;
    ev_t qa[$];
    ev_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes, stamped with the number of clock edges seen so far.
    always @(negedge clk) begin
        if (valid_a || err_a) qa.push_back('{cyc, valid_a, err_a, data_a});
        if (valid_b || err_b) qb.push_back('{cyc, valid_b, err_b, {1'b0, data_b}});
        if (busy_a) busy_cnt_a++;
        if (valid_a && err_a) both_cnt++;
        if (valid_b && err_b) both_cnt++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int exp_cyc(input int e0, input int os, input int nb);
        return e0 + 2 + os / 2 + (nb + 1) * os;
    endfunction

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call 1 time unit after a rising edge. When it returns, the line is left
    // at the stop-bit level, again 1 time unit after a rising edge.
    task automatic send_frame(input bit sel, input logic [7:0] d, input int nb,
                              input int os, input logic stop, output int e0);
        e0 = cyc + 1;
        set_line(sel, 1'b0);
        idle(os);
        for (int i = 0; i < nb; i++) begin
            set_line(sel, d[i]);
            idle(os);
        end
        set_line(sel, stop);
        idle(os);
    endtask

    task automatic expect_ev(input bit sel, input string name, input int ecyc,
                             input bit v, input bit e, input logic [7:0] d);
        ev_t ev;
        int  sz;
        sz = sel ? qb.size() : qa.size();
        if (sz == 0) begin
            check({name, " strobe present"}, 0, 1);
        end else begin
            if (sel) ev = qb.pop_front();
            else ev = qa.pop_front();
            check({name, " cycle"}, ev.cyc, ecyc);
            check({name, " valid"}, ev.v, v);
            check({name, " err"}, ev.e, e);
            check({name, " data"}, ev.d, d);
        end
    endtask

    initial begin
        vec_t       tbl [5];
        int         e0, e1, b0;
        logic [7:0] last_good;
        ev_t        exp_q[$];

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};

        nrst = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data", data_a, 0);
        check("reset valid", valid_a, 0);
        check("reset err", err_a, 0);
        check("reset busy", busy_a, 0);
        nrst = 1'b1;
        idle(4);

        // Table-driven single frames, with the line returned to idle after each.
        for (int k = 0; k < 5; k++) begin
            send_frame(1'b0, tbl[k].d, 8, 8, tbl[k].stop, e0);
            set_line(1'b0, 1'b1);
            idle(20);
            expect_ev(1'b0, $sformatf("tbl%0d", k), exp_cyc(e0, 8, 8),
                      tbl[k].exp_v, tbl[k].exp_e, tbl[k].exp_d);
            check($sformatf("tbl%0d held data", k), data_a, tbl[k].exp_d);
        end

        // Two frames sent back to back with no idle gap between them.
        send_frame(1'b0, 8'h00, 8, 8, 1'b1, e0);
        send_frame(1'b0, 8'hFF, 8, 8, 1'b1, e1);
        idle(20);
        expect_ev(1'b0, "b2b first", exp_cyc(e0, 8, 8), 1'b1, 1'b0, 8'h00);
        expect_ev(1'b0, "b2b second", exp_cyc(e1, 8, 8), 1'b1, 1'b0, 8'hFF);

        // A 3-cycle low glitch must be rejected.
        b0 = busy_cnt_a;
        set_line(1'b0, 1'b0);
        idle(3);
        set_line(1'b0, 1'b1);
        idle(20);
        check("glitch busy within 1..4", int'((busy_cnt_a - b0) >= 1 && (busy_cnt_a - b0) <= 4), 1);
        check("glitch no strobe", qa.size(), 0);

        // Low stop bit, then the line is held low for 40 more cycles.
        send_frame(1'b0, 8'h3C, 8, 8, 1'b0, e0);
        b0 = busy_cnt_a;
        idle(40);
        check("break busy held", busy_cnt_a - b0, 40);
        expect_ev(1'b0, "break", exp_cyc(e0, 8, 8), 1'b0, 1'b1, 8'hFF);
        check("break no new frame", qa.size(), 0);
        set_line(1'b0, 1'b1);
        idle(1);
        check("break busy before release", busy_a, 1);
        idle(4);
        check("break busy after release", busy_a, 0);
        check("break data kept", data_a, 8'hFF);

        // Reset after data bit 3 of a frame.
        set_line(1'b0, 1'b0);
        idle(8);
        for (int i = 0; i < 4; i++) begin
            set_line(1'b0, (8'hC3 >> i) & 1);
            idle(8);
        end
        nrst = 1'b0;
        set_line(1'b0, 1'b1);
        @(negedge clk);
        check("midreset data", data_a, 0);
        check("midreset busy", busy_a, 0);
        check("midreset valid", valid_a, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        idle(30);
        check("midreset no strobe", qa.size(), 0);
        send_frame(1'b0, 8'h5A, 8, 8, 1'b1, e0);
        idle(20);
        expect_ev(1'b0, "after reset", exp_cyc(e0, 8, 8), 1'b1, 1'b0, 8'h5A);

        // Instance B: 16x oversampling, 7 data bits.
        send_frame(1'b1, 8'h55, 7, 16, 1'b1, e0);
        idle(30);
        expect_ev(1'b1, "os16", exp_cyc(e0, 16, 7), 1'b1, 1'b0, 8'h55);
        check("os16 held data", data_b, 7'h55);

        // Random frames. The model records each frame's outcome from its
        // stop bit and remembers the last good word.
        last_good = 8'h5A;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d;
            logic       stop;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            gap  = $urandom_range(0, 6);
            send_frame(1'b0, d, 8, 8, stop, e0);
            if (stop) begin
                last_good = d;
                exp_q.push_back('{exp_cyc(e0, 8, 8), 1'b1, 1'b0, d});
                if (gap > 0) idle(gap);
            end else begin
                exp_q.push_back('{exp_cyc(e0, 8, 8), 1'b0, 1'b1, last_good});
                set_line(1'b0, 1'b1);
                idle(gap + 4);
            end
        end
        idle(20);
        for (int k = 0; k < exp_q.size(); k++) begin
            expect_ev(1'b0, $sformatf("rand%0d", k), exp_q[k].cyc,
                      exp_q[k].v, exp_q[k].e, exp_q[k].d);
        end
        check("rand final data", data_a, last_good);

        check("leftover strobes A", qa.size(), 0);
        check("leftover strobes B", qb.size(), 0);
        check("valid and err together", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
